// File: rtl/led_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_driver
//  Description : Per-channel PWM LED driver with linear fade. Each bit of the
//                incoming LED bus sets a target (on/off). The channel duty
//                moves one step toward that target per fade tick, which gives
//                a soft fade-in/fade-out instead of a hard toggle.
//  Ports       : clk       - system clock, rising edge
//                rst_n     - asynchronous active-low reset
//                i_led     - target level per channel (1=on, 0=off)
//                i_enable  - 1=run, 0=force dark and clear fade state
//                o_pwm     - registered PWM drive per channel
//                o_idle    - registered, 1 when every duty sits on its target
//  Revision    : 1.0 - initial release
// ============================================================================
module led_fade_driver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int PWM_FREQ   = 1_000,
    parameter int PWM_BITS   = 8,
    parameter int FADE_MS    = 250,
    parameter int BUS_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] i_led,
    input  logic                 i_enable,
    output logic [BUS_WIDTH-1:0] o_pwm,
    output logic                 o_idle
);

    // Divider arithmetic is done in 64 bits: CLOCK_FREQ*FADE_MS overflows 32.
    localparam longint c_DMAX_L       = (longint'(1) << PWM_BITS) - 1;
    localparam longint c_PWM_DIV_RAW  = longint'(CLOCK_FREQ) /
                                        (longint'(PWM_FREQ) * (longint'(1) << PWM_BITS));
    localparam longint c_STEP_DIV_RAW = (longint'(CLOCK_FREQ) * longint'(FADE_MS)) /
                                        (longint'(1000) * c_DMAX_L);
    localparam longint c_PWM_DIV      = (c_PWM_DIV_RAW  < 1) ? 1 : c_PWM_DIV_RAW;
    localparam longint c_STEP_DIV     = (c_STEP_DIV_RAW < 1) ? 1 : c_STEP_DIV_RAW;

    localparam int c_PWM_PW  = (c_PWM_DIV  > 1) ? $clog2(c_PWM_DIV)  : 1;
    localparam int c_STEP_PW = (c_STEP_DIV > 1) ? $clog2(c_STEP_DIV) : 1;

    localparam logic [c_PWM_PW-1:0]  c_PWM_LAST  = c_PWM_PW'(c_PWM_DIV - 1);
    localparam logic [c_PWM_PW-1:0]  c_PWM_ONE   = c_PWM_PW'(1);
    localparam logic [c_STEP_PW-1:0] c_STEP_LAST = c_STEP_PW'(c_STEP_DIV - 1);
    localparam logic [c_STEP_PW-1:0] c_STEP_ONE  = c_STEP_PW'(1);
    localparam logic [PWM_BITS-1:0]  c_DMAX      = '1;
    localparam logic [PWM_BITS-1:0]  c_ZERO      = '0;
    localparam logic [PWM_BITS-1:0]  c_ONE       = PWM_BITS'(1);

    logic [c_PWM_PW-1:0]  r_pwm_pre;
    logic [c_STEP_PW-1:0] r_step_pre;
    logic [PWM_BITS-1:0]  r_cnt;
    logic                 r_idle;
    logic                 w_pwm_tick;
    logic                 w_step_tick;
    logic                 w_wrap;
    logic [BUS_WIDTH-1:0] w_on_target;

    // With a divide-by-1 the counters stay at 0 and the tick fires every clock.
    assign w_pwm_tick  = (r_pwm_pre  == c_PWM_LAST);
    assign w_step_tick = (r_step_pre == c_STEP_LAST);
    // Period boundary: the tick that takes the PWM counter from DMAX back to 0.
    assign w_wrap      = w_pwm_tick && (r_cnt == c_DMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_pre  <= '0;
            r_step_pre <= '0;
            r_cnt      <= '0;
        end else if (!i_enable) begin
            r_pwm_pre  <= '0;
            r_step_pre <= '0;
            r_cnt      <= '0;
        end else begin
            r_pwm_pre  <= w_pwm_tick  ? '0 : r_pwm_pre  + c_PWM_ONE;
            r_step_pre <= w_step_tick ? '0 : r_step_pre + c_STEP_ONE;
            if (w_pwm_tick) begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] r_duty;
            logic [PWM_BITS-1:0] r_shadow;
            logic                r_pwm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_duty   <= '0;
                    r_shadow <= '0;
                    r_pwm    <= 1'b0;
                end else if (!i_enable) begin
                    r_duty   <= '0;
                    r_shadow <= '0;
                    r_pwm    <= 1'b0;
                end else begin
                    // Saturating ramp; a target change simply reverses the
                    // direction from wherever the duty currently is.
                    if (w_step_tick) begin
                        if (i_led[gi] && (r_duty != c_DMAX)) begin
                            r_duty <= r_duty + c_ONE;
                        end else if (!i_led[gi] && (r_duty != c_ZERO)) begin
                            r_duty <= r_duty - c_ONE;
                        end
                    end
                    // Shadow only updates at the period boundary so a period
                    // never mixes two duty values.
                    if (w_wrap) begin
                        r_shadow <= r_duty;
                    end
                    // Full scale forces a solid 1; cnt < DMAX would leave a
                    // one-slot gap each period.
                    r_pwm <= (r_shadow == c_DMAX) || (r_cnt < r_shadow);
                end
            end

            assign w_on_target[gi] = (r_duty == (i_led[gi] ? c_DMAX : c_ZERO));
            assign o_pwm[gi]       = r_pwm;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= 1'b1;
        end else if (!i_enable) begin
            // Duties are being cleared, so only an all-off target is settled.
            r_idle <= (i_led == '0);
        end else begin
            r_idle <= &w_on_target;
        end
    end

    assign o_idle = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fade_driver
//  Description : Self-checking bench for led_fade_driver. A cycle-level
//                reference model derives tick timing from the edge count
//                since the last clear and checks o_pwm / o_idle every clock,
//                with directed scenarios followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade_driver;

    localparam int c_CLOCK_FREQ = 25600;
    localparam int c_PWM_FREQ   = 100;
    localparam int c_PWM_BITS   = 4;
    localparam int c_FADE_MS    = 150;
    localparam int c_BUS_WIDTH  = 4;

    localparam int c_DMAX     = 15;
    localparam int c_PWM_DIV  = 16;
    localparam int c_PERIOD   = c_PWM_DIV * 16;
    localparam int c_STEP_DIV = 256;

    logic       clk;
    logic       rst_n;
    logic [3:0] led;
    logic       en;
    logic [3:0] o_pwm;
    logic       o_idle;

    int n_cmp;
    int n_fail;

    // Reference model state
    int         m_n;
    int         m_duty   [4];
    int         m_shadow [4];
    logic [3:0] m_pwm;
    logic       m_idle;

    led_fade_driver #(
        .CLOCK_FREQ (c_CLOCK_FREQ),
        .PWM_FREQ   (c_PWM_FREQ),
        .PWM_BITS   (c_PWM_BITS),
        .FADE_MS    (c_FADE_MS),
        .BUS_WIDTH  (c_BUS_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_led    (led),
        .i_enable (en),
        .o_pwm    (o_pwm),
        .o_idle   (o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input logic idle_val);
        m_n = 0;
        for (int i = 0; i < 4; i++) begin
            m_duty[i]   = 0;
            m_shadow[i] = 0;
        end
        m_pwm  = 4'b0000;
        m_idle = idle_val;
    endtask

    // Advance the model over one rising edge using the inputs present now,
    // then wait for that edge and compare both outputs.
    task automatic tick();
        int         cnt_b;
        logic [3:0] p;
        logic       id;
        if (!rst_n) begin
            model_clear(1'b1);
        end else if (!en) begin
            model_clear(led == 4'b0000);
        end else begin
            cnt_b = (m_n / c_PWM_DIV) % 16;
            id    = 1'b1;
            for (int i = 0; i < 4; i++) begin
                p[i] = (m_shadow[i] == c_DMAX) || (cnt_b < m_shadow[i]);
                if (m_duty[i] != (led[i] ? c_DMAX : 0)) id = 1'b0;
            end
            m_n++;
            if (m_n % c_PERIOD == 0) begin
                for (int i = 0; i < 4; i++) m_shadow[i] = m_duty[i];
            end
            if (m_n % c_STEP_DIV == 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (led[i] && m_duty[i] < c_DMAX) m_duty[i]++;
                    else if (!led[i] && m_duty[i] > 0) m_duty[i]--;
                end
            end
            m_pwm  = p;
            m_idle = id;
        end
        @(posedge clk);
        #1;
        check("pwm",  {28'd0, o_pwm},  {28'd0, m_pwm});
        check("idle", {31'd0, o_idle}, {31'd0, m_idle});
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    initial begin
        int   high_cnt;
        int   rise_cnt;
        logic prev;
        logic first;
        logic reached;

        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        led    = 4'b0000;
        en     = 1'b1;
        model_clear(1'b1);

        // 1: reset held, then released with all targets off
        run(5);
        check("reset_pwm",  {28'd0, o_pwm},  32'h0);
        check("reset_idle", {31'd0, o_idle}, 32'h1);
        rst_n = 1'b1;
        run(300);
        check("post_reset_idle", {31'd0, o_idle}, 32'h1);

        // 2: fade-in on channel 0
        led = 4'b0001;
        run(2);
        check("fadein_idle_drop", {31'd0, o_idle}, 32'h0);
        run(3840 + 600);
        check("fadein_full_pwm",  {28'd0, o_pwm},  32'h1);
        check("fadein_full_idle", {31'd0, o_idle}, 32'h1);

        // 3: mid-ramp duty 8 gives a single 128-clock pulse per period
        en = 1'b0;
        run(1);
        en = 1'b1;
        run(9 * c_STEP_DIV);
        high_cnt = 0;
        rise_cnt = 0;
        prev     = o_pwm[0];
        first    = 1'b0;
        for (int k = 0; k < c_PERIOD; k++) begin
            tick();
            if (k == 0) first = o_pwm[0];
            if (o_pwm[0]) high_cnt++;
            if (o_pwm[0] && !prev) rise_cnt++;
            prev = o_pwm[0];
        end
        check("mid_high_count", high_cnt, 128);
        check("mid_pulse_count", rise_cnt, 1);
        check("mid_pulse_start", {31'd0, first}, 32'h1);
        check("mid_others_dark", {29'd0, o_pwm[3:1]}, 32'h0);

        // 4: fade-out from full, reversal at duty 7
        run(3840 + 600);
        check("rev_full_pwm", {28'd0, o_pwm}, 32'h1);
        led     = 4'b0000;
        reached = 1'b0;
        for (int k = 0; k < 5000 && !reached; k++) begin
            tick();
            if (m_duty[0] == 7) reached = 1'b1;
        end
        check("rev_reach_duty7", {31'd0, reached}, 32'h1);
        led = 4'b0001;
        run(3840 + 600);
        check("rev_full_pwm2", {28'd0, o_pwm},  32'h1);
        check("rev_idle",      {31'd0, o_idle}, 32'h1);

        // 5: enable drop at duty 5, re-enable, then async reset mid-fade
        en = 1'b0;
        run(1);
        en = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 3000 && !reached; k++) begin
            tick();
            if (m_duty[0] == 5) reached = 1'b1;
        end
        check("en_reach_duty5", {31'd0, reached}, 32'h1);
        run(40);
        en = 1'b0;
        run(1);
        check("en_off_pwm",  {28'd0, o_pwm},  32'h0);
        check("en_off_idle", {31'd0, o_idle}, 32'h0);
        run(10);
        en = 1'b1;
        run(1500);
        rst_n = 1'b0;
        #1;
        model_clear(1'b1);
        check("async_rst_pwm",  {28'd0, o_pwm},  32'h0);
        check("async_rst_idle", {31'd0, o_idle}, 32'h1);
        run(3);
        rst_n = 1'b1;
        run(1000);

        // 6: saturation with all channels on
        led = 4'b1111;
        run(10000);
        check("sat_pwm",  {28'd0, o_pwm},  32'hF);
        check("sat_idle", {31'd0, o_idle}, 32'h1);

        // 7: randomized targets with occasional enable drops
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 299) == 0) led = 4'($urandom);
            en = ($urandom_range(0, 1499) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
